// File: rtl/float_fix_sched_pkg.sv
// Shared definitions for the float-to-fixed scheduler.
// Holds the scheduler FSM state encoding, the IEEE-754 single-precision
// field constants and the two's-complement saturation values.
package float_fix_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] EXP_MAX = '1;

    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/float_fix_sched_f2x_core.sv
// f2x_core: purely combinational IEEE-754 single -> 32-bit two's-complement
// fixed-point converter. The result is truncated toward zero and saturated.
// Ports:
//   flt  : IEEE-754 single operand
//   pos  : number of fraction bits in the result
//   data : two's-complement fixed-point result
//   ovf  : result was saturated (also set for Inf/NaN)
module f2x_core
    import float_fix_sched_pkg::*;
#(
    parameter int FRAC_W = 5
) (
    input  logic [31:0]       flt,
    input  logic [FRAC_W-1:0] pos,
    output logic [31:0]       data,
    output logic              ovf
);

    // The 24-bit integer mantissa {1,m} carries an implicit 2^-23, so the
    // net shift applied to it is e + pos - (bias + 23).
    localparam logic signed [10:0] SH_OFS = 11'(EXP_BIAS + MAN_W);

    logic              sign;
    logic [EXP_W-1:0]  expo;
    logic [MAN_W:0]    mant;
    logic signed [10:0] sh;
    logic [10:0]       rsh;
    logic [32:0]       mag;
    logic              big;

    assign sign = flt[31];
    assign expo = flt[30:23];
    assign mant = {1'b1, flt[22:0]};
    assign sh   = $signed(11'(expo)) + $signed(11'(pos)) - SH_OFS;
    assign rsh  = 11'(-sh);

    // Magnitude after shifting. A left shift of 9 or more pushes the leading
    // one to bit 32 or beyond, which always saturates in either sign, so it
    // is flagged instead of computed.
    always_comb begin
        mag = '0;
        big = 1'b0;
        if (!sh[10]) begin
            if (sh >= 11'sd9) begin
                big = 1'b1;
            end else begin
                mag = 33'(mant) << sh[3:0];
            end
        end else if (rsh < 11'd32) begin
            mag = 33'(mant) >> rsh[4:0];
        end
    end

    always_comb begin
        data = '0;
        ovf  = 1'b0;
        if (expo == '0) begin
            // zero and denormals (either sign) convert to 0
            data = '0;
        end else if (expo == EXP_MAX) begin
            ovf  = 1'b1;
            data = sign ? SAT_NEG : SAT_POS;
        end else if (!sign) begin
            if (big || (mag > {1'b0, SAT_POS})) begin
                ovf  = 1'b1;
                data = SAT_POS;
            end else begin
                data = mag[31:0];
            end
        end else begin
            // -2^31 itself is representable, so only strictly larger saturates
            if (big || (mag > {1'b0, SAT_NEG})) begin
                ovf  = 1'b1;
                data = SAT_NEG;
            end else begin
                data = 32'd0 - mag[31:0];
            end
        end
    end

endmodule

// File: rtl/float_fix_sched.sv
// float_fix_sched: two-requester round-robin scheduler around a single
// float-to-fixed converter. One conversion in flight: IDLE -> CALC -> HOLD.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : per-requester handshake (ready only in IDLE)
//   req_float           : per-requester IEEE-754 operand, requester i at [32*i +: 32]
//   req_pos             : per-requester fraction-bit count, requester i at [FRAC_W*i +: FRAC_W]
//   res_valid/res_ready : result handshake
//   res_data, res_id, res_ovf : fixed-point result, owning requester, saturation flag
module float_fix_sched
    import float_fix_sched_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int FRAC_W = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*32-1:0]       req_float,
    input  logic [NREQ*FRAC_W-1:0]   req_pos,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [31:0]              res_data,
    output logic                     res_id,
    output logic                     res_ovf
);

    state_t              state_reg;
    logic                last_grant_reg;
    logic [31:0]         flt_reg;
    logic [FRAC_W-1:0]   pos_reg;
    logic                id_reg;
    logic                res_valid_reg;
    logic [31:0]         res_data_reg;
    logic                res_id_reg;
    logic                res_ovf_reg;

    logic [31:0]         flt_arr [NREQ];
    logic [FRAC_W-1:0]   pos_arr [NREQ];
    logic                grant_id;
    logic                grant_en;
    logic [31:0]         core_data;
    logic                core_ovf;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign flt_arr[gi] = req_float[gi*32 +: 32];
            assign pos_arr[gi] = req_pos[gi*FRAC_W +: FRAC_W];
        end
    endgenerate

    // Round robin: on contention take the requester not granted last time.
    always_comb begin
        grant_id = 1'b0;
        if (req_valid[0] && req_valid[1]) begin
            grant_id = ~last_grant_reg;
        end else if (req_valid[1]) begin
            grant_id = 1'b1;
        end
    end

    assign grant_en = (state_reg == ST_IDLE) && (|req_valid) && !rst;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_id == 1'(gi));
        end
    endgenerate

    f2x_core #(
        .FRAC_W (FRAC_W)
    ) u_core (
        .flt  (flt_reg),
        .pos  (pos_reg),
        .data (core_data),
        .ovf  (core_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            last_grant_reg <= 1'b1;
            flt_reg        <= '0;
            pos_reg        <= '0;
            id_reg         <= 1'b0;
            res_valid_reg  <= 1'b0;
            res_data_reg   <= '0;
            res_id_reg     <= 1'b0;
            res_ovf_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (grant_en) begin
                        flt_reg        <= flt_arr[grant_id];
                        pos_reg        <= pos_arr[grant_id];
                        id_reg         <= grant_id;
                        last_grant_reg <= grant_id;
                        state_reg      <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    res_data_reg  <= core_data;
                    res_ovf_reg   <= core_ovf;
                    res_id_reg    <= id_reg;
                    res_valid_reg <= 1'b1;
                    state_reg     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_reg <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;
    assign res_ovf   = res_ovf_reg;

endmodule

// File: tb/tb_float_fix_sched.sv
// Directed testbench for float_fix_sched with hand-computed expected values.
module tb_float_fix_sched;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_float;
    logic [9:0]  req_pos;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_id;
    logic        res_ovf;

    int test_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;

    float_fix_sched #(
        .NREQ   (2),
        .FRAC_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_float (req_float),
        .req_pos   (req_pos),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        test_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_id_ovf", {30'd0, res_id, res_ovf}, 32'd0);
        req_valid = 2'b11;
        #1 check("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = 2'b00;
        rst = 1'b0;
    endtask

    // One request from requester r; res_ready held low for 'hold' cycles in HOLD.
    task automatic send_one(input int r, input logic [31:0] f, input logic [4:0] p,
                            input logic [31:0] ed, input logic eo, input int hold);
        @(negedge clk);
        req_valid = 2'b00;
        req_valid[r] = 1'b1;
        req_float[r*32 +: 32] = f;
        req_pos[r*5 +: 5] = p;
        res_ready = (hold == 0);
        #1 check("grant_ready", 32'(req_ready), 32'd1 << r);
        @(negedge clk);
        // inputs change after grant must not affect the in-flight result
        req_valid = 2'b00;
        req_float = '1;
        req_pos = '1;
        check("calc_res_valid", 32'(res_valid), 32'd0);
        check("calc_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("hold_res_valid", 32'(res_valid), 32'd1);
        check("res_data", res_data, ed);
        check("res_id", 32'(res_id), 32'(r));
        check("res_ovf", 32'(res_ovf), 32'(eo));
        for (int i = 0; i < hold; i++) begin
            req_valid = 2'b11;
            #1 check("stall_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("stall_res_valid", 32'(res_valid), 32'd1);
            check("stall_res_data", res_data, ed);
        end
        req_valid = 2'b00;
        res_ready = 1'b1;
        @(negedge clk);
        check("after_hs_valid", 32'(res_valid), 32'd0);
    endtask

    initial begin
        int last_cyc;
        int waited;
        rst = 1'b1;
        req_valid = 2'b00;
        req_float = '0;
        req_pos = '0;
        res_ready = 1'b1;

        do_reset();

        // basic conversions
        send_one(0, 32'h3FC0_0000, 5'd8, 32'h0000_0180, 1'b0, 0);   // 1.5 * 2^8
        send_one(1, 32'hC000_0000, 5'd4, 32'hFFFF_FFE0, 1'b0, 0);   // -2.0 * 2^4
        send_one(0, 32'h4F00_0000, 5'd0, 32'h7FFF_FFFF, 1'b1, 0);   // 2^31 saturates
        send_one(0, 32'hCF00_0000, 5'd0, 32'h8000_0000, 1'b0, 0);   // exactly -2^31
        send_one(0, 32'h7F80_0000, 5'd0, 32'h7FFF_FFFF, 1'b1, 0);   // +Inf
        send_one(1, 32'hFFC0_0000, 5'd3, 32'h8000_0000, 1'b1, 0);   // negative NaN
        send_one(1, 32'h8000_0000, 5'd9, 32'h0000_0000, 1'b0, 0);   // -0
        send_one(0, 32'h0040_0000, 5'd31, 32'h0000_0000, 1'b0, 0);  // denormal
        send_one(1, 32'hBFE0_0000, 5'd2, 32'hFFFF_FFF9, 1'b0, 0);   // -1.75 * 4 = -7
        send_one(0, 32'hBF00_0000, 5'd0, 32'h0000_0000, 1'b0, 0);   // -0.5 truncates to 0
        send_one(1, 32'h4EFF_FFFF, 5'd0, 32'h7FFF_FF80, 1'b0, 0);   // largest below 2^31
        send_one(0, 32'h3380_0000, 5'd31, 32'h0000_0080, 1'b0, 0);  // 2^-24 * 2^31
        send_one(1, 32'h0080_0000, 5'd31, 32'h0000_0000, 1'b0, 0);  // right shift >= 32
        send_one(0, 32'h4B00_0001, 5'd9, 32'h7FFF_FFFF, 1'b1, 0);   // large left shift

        // backpressure: 5 stall cycles in HOLD
        send_one(1, 32'h4120_0000, 5'd1, 32'h0000_0014, 1'b0, 5);  // 10.0 * 2 = 20

        // both requesters continuously valid from reset: 0,1,0,1 every 3 cycles
        do_reset();
        @(negedge clk);
        req_float[31:0]  = 32'h3F80_0000;  // +1.0
        req_float[63:32] = 32'hBF80_0000;  // -1.0
        req_pos = '0;
        res_ready = 1'b1;
        req_valid = 2'b11;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            while (res_valid !== 1'b1 && waited < 8) begin
                @(negedge clk);
                waited++;
            end
            if (res_valid !== 1'b1) begin
                check("rr_timeout", 32'(res_valid), 32'd1);
                break;
            end
            check("rr_res_id", 32'(res_id), 32'(k % 2));
            check("rr_res_data", res_data, (k % 2 == 0) ? 32'h0000_0001 : 32'hFFFF_FFFF);
            if (k > 0) check("rr_interval", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            if (k == 3) req_valid = 2'b00;
            @(negedge clk);
        end
        req_valid = 2'b00;
        repeat (3) @(negedge clk);

        // reset during HOLD: result discarded, requester 0 wins afterwards
        @(negedge clk);
        req_valid = 2'b01;
        req_float[31:0] = 32'h3FC0_0000;
        req_pos[4:0] = 5'd8;
        res_ready = 1'b0;
        #1 check("pre_rst_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check("pre_rst_hold", 32'(res_valid), 32'd1);
        rst = 1'b1;
        res_ready = 1'b1;
        @(negedge clk);
        check("rst_hold_valid", 32'(res_valid), 32'd0);
        check("rst_hold_data", res_data, 32'd0);
        rst = 1'b0;
        req_valid = 2'b11;
        #1 check("post_rst_grant", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        check("post_rst_id", 32'(res_id), 32'd0);
        check("post_rst_data", res_data, 32'h0000_0180);
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule

// File: doc/float_fix_sched.md
FLOAT_FIX_SCHED -- requirements
Module: float_fix_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning number of requesters (fixed at 2 in this revision).
REQ-002 SHALL have parameter FRAC_W, default 5, meaning width of the fixed-point position field.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  2  per-requester request valid.
REQ-006 req_ready  output  2  per-requester accept; a request transfers when valid&ready on the same edge.
REQ-007 req_float  input  2x32  IEEE-754 single operand per requester.
REQ-008 req_pos  input  2x5  binary-point position per requester (count of fraction bits in the result).
REQ-009 res_valid  output  1  result valid.
REQ-010 res_ready  input  1  consumer accept.
REQ-011 res_data  output  32  two's-complement fixed-point result.
REQ-012 res_id  output  1  index of the requester that owns res_data.
REQ-013 res_ovf  output  1  set when the result was saturated.

Function
REQ-014 SHALL implement FSM IDLE -> CALC -> HOLD -> IDLE; exactly one conversion is in flight at a time.
REQ-015 IDLE: if any req_valid, grant one requester, assert only its req_ready combinationally in that cycle, capture float/pos/id, go to CALC; req_ready is 0 in CALC and HOLD.
REQ-016 Arbitration SHALL be round-robin: on simultaneous valids, grant the requester not granted last; a lone valid is always granted; the last-grant pointer resets to 1, so requester 0 wins first.
REQ-017 CALC: one cycle; register the conversion into res_data/res_ovf; go to HOLD.
REQ-018 HOLD: res_valid=1; res_data/res_id/res_ovf stable until res_valid&res_ready; on handshake go to IDLE (no new grant in that same cycle).
REQ-019 Latency: grant edge to res_valid = 2 cycles; minimum issue interval = 3 cycles.
REQ-020 Conversion value = (-1)^s * 1.m * 2^(e-127) * 2^pos, truncated toward zero, expressed in 32-bit two's complement.
REQ-021 e=0 (zero/denormal) SHALL give 0 with ovf=0, including -0.
REQ-022 e=255 (Inf/NaN) SHALL saturate: positive sign -> 0x7FFFFFFF, negative sign -> 0x80000000; ovf=1; NaN follows its sign bit.
REQ-023 Saturation SHALL apply when the truncated magnitude exceeds 2^31-1 (positive) or 2^31 (negative); exactly -2^31 is 0x80000000 with ovf=0.
REQ-024 Right shifts of 32 or more SHALL give 0; negation SHALL be arithmetic two's complement, not logical inversion.
REQ-025 Requester inputs sampled only at grant; later changes do not affect the in-flight result.

Reset
REQ-026 On rst: state=IDLE, res_valid=0, res_data=0, res_id=0, res_ovf=0, req_ready=0, last-grant=1.
REQ-027 rst asserted in CALC or HOLD SHALL discard the in-flight result with no res_valid pulse; rst dominates a simultaneous handshake.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, the float field constants (bias 127, exponent/mantissa widths), and the saturation constants 0x7FFFFFFF/0x80000000.
REQ-029 Conversion arithmetic SHALL be a separate combinational sub-module f2x_core (float, pos -> data, ovf); the scheduler owns all registers.

Verification
REQ-030 Requester 0 sends 0x3FC00000 (1.5), pos=8; res_ready=1 -> res_data=0x00000180, res_id=0, ovf=0, res_valid 2 cycles after grant.
REQ-031 Requester 1 sends 0xC0000000 (-2.0), pos=4 -> res_data=0xFFFFFFE0, res_id=1, ovf=0.
REQ-032 Both valid continuously, from reset -> grants alternate 0,1,0,1; results arrive with res_id matching, one per 3 cycles.
REQ-033 Requester 0 sends 0x4F000000 (2^31), pos=0 -> 0x7FFFFFFF, ovf=1; 0xCF000000, pos=0 -> 0x80000000, ovf=0; 0x7F800000 -> 0x7FFFFFFF, ovf=1.
REQ-034 res_ready held 0 for 5 cycles in HOLD -> res_data stable, both req_ready=0; release -> single transfer, then IDLE.
REQ-035 rst pulsed during HOLD -> res_valid drops next edge, no result delivered; the next simultaneous request grants requester 0.
